sd_dac: RTL and testbench

SD_DAC -- requirements
Module: sd_dac

---
 rtl/sd_dac_pkg.sv | 11 +
 rtl/sd_dac_mod.sv | 31 +++
 rtl/sd_dac.sv | 113 +++++++++++
 tb/tb_sd_dac.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_dac_pkg.sv
// Shared definitions for the first-order delta-sigma DAC.
package sd_dac_pkg;

  localparam int unsigned state_w = 1;

  typedef enum logic [state_w-1:0] {
    s_idle = 1'b0,
    s_run  = 1'b1
  } state_t;

endpackage

// File: rtl/sd_dac_mod.sv
// First-order delta-sigma modulator: accumulator plus registered carry output.
module sd_dac_mod #(
  parameter int unsigned p_bit_cnt = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [p_bit_cnt-1:0] i_sample,
  input  logic                 i_enable,
  input  logic                 i_clear,
  output logic                 o_dac
);

  logic [p_bit_cnt-1:0] acc;
  logic [p_bit_cnt:0]   sum;

  // The accumulator's carry bit lives in o_dac; only the residue is fed back.
  always_comb begin
    sum = {1'b0, acc} + {1'b0, i_sample};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      acc   <= '0;
      o_dac <= 1'b0;
    end else if (i_enable) begin
      acc   <= sum[p_bit_cnt-1:0];
      o_dac <= sum[p_bit_cnt];
    end
  end

endmodule

// File: rtl/sd_dac.sv
// Delta-sigma DAC: one-entry sample buffer, period counter and run/idle control.
module sd_dac
  import sd_dac_pkg::*;
#(
  parameter int unsigned p_bit_cnt = 8,
  parameter int unsigned p_osr     = 256
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [p_bit_cnt-1:0] i_data,
  output logic                 o_busy,
  output logic                 o_load,
  output logic                 o_underrun,
  output logic                 o_dac
);

  localparam int unsigned           cnt_w    = $clog2(p_osr);
  localparam logic [cnt_w-1:0]      cnt_last = cnt_w'(p_osr - 1);

  state_t               state;
  state_t               state_nx;
  logic                 buf_full;
  logic [p_bit_cnt-1:0] buf_data;
  logic [p_bit_cnt-1:0] active;
  logic [cnt_w-1:0]     cnt;
  logic                 boundary;
  logic                 load;
  logic                 underrun;
  logic                 accept;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    underrun = 1'b0;
    boundary = (cnt == cnt_last);
    accept   = i_valid && !buf_full;
    unique case (state)
      s_idle: begin
        if (i_enable && buf_full) begin
          load     = 1'b1;
          state_nx = s_run;
        end
      end
      s_run: begin
        // Stop request outranks a pending sample, which stays buffered.
        if (boundary) begin
          if (!i_enable) begin
            state_nx = s_idle;
          end else if (buf_full) begin
            load = 1'b1;
          end else begin
            underrun = 1'b1;
          end
        end
      end
      default: state_nx = s_idle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= s_idle;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      buf_full   <= 1'b0;
      buf_data   <= '0;
      active     <= '0;
      cnt        <= '0;
      o_load     <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_load     <= load;
      o_underrun <= underrun;
      if (load) begin
        active   <= buf_data;
        buf_full <= 1'b0;
      end else if (accept) begin
        buf_data <= i_data;
        buf_full <= 1'b1;
      end
      if (state == s_run) begin
        cnt <= boundary ? '0 : cnt + cnt_w'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    o_ready = !buf_full;
    o_busy  = (state == s_run);
  end

  sd_dac_mod #(
    .p_bit_cnt(p_bit_cnt)
  ) u_mod (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sample(active),
    .i_enable(state == s_run),
    .i_clear (state == s_idle),
    .o_dac   (o_dac)
  );

endmodule

// File: tb/tb_sd_dac.sv
// Scoreboard bench for sd_dac: per-period ones counts against a residue arithmetic model.
module tb_sd_dac;

  localparam int BITS = 4;
  localparam int OSR  = 16;
  localparam int MOD  = 1 << BITS;

  typedef struct packed {
    logic [BITS-1:0] code;
    logic            fresh;
  } exp_t;

  logic            clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_enable = 1'b0;
  logic            i_valid = 1'b0;
  logic [BITS-1:0] i_data = '0;
  logic            o_ready, o_busy, o_load, o_underrun, o_dac;

  logic            i_enable20 = 1'b0;
  logic            i_valid20 = 1'b0;
  logic [BITS-1:0] i_data20 = '0;
  logic            o_ready20, o_busy20, o_load20, o_underrun20, o_dac20;

  int   checks = 0;
  int   failures = 0;
  int   loads_seen = 0;
  int   unders_seen = 0;
  bit   done20 = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  sd_dac #(.p_bit_cnt(BITS), .p_osr(OSR)) u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .o_ready(o_ready), .i_data(i_data), .o_busy(o_busy), .o_load(o_load),
    .o_underrun(o_underrun), .o_dac(o_dac)
  );

  sd_dac #(.p_bit_cnt(BITS), .p_osr(20)) u_dut20 (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable20), .i_valid(i_valid20),
    .o_ready(o_ready20), .i_data(i_data20), .o_busy(o_busy20), .o_load(o_load20),
    .o_underrun(o_underrun20), .o_dac(o_dac20)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a period is the OSR cycles following a load or underrun pulse.
  int win_cnt = 0, win_ones = 0, win_exp = 0, residue = 0, cur_code = 0;
  bit win_on = 1'b0;

  task automatic open_window();
    int total;
    total    = residue + OSR * cur_code;
    win_exp  = total / MOD;
    residue  = total % MOD;
    win_cnt  = 0;
    win_ones = 0;
    win_on   = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (i_reset) begin
      win_on  = 1'b0;
      residue = 0;
    end else begin
      if (win_on) begin
        win_ones += int'(o_dac);
        win_cnt++;
        if (win_cnt == OSR) begin
          check($sformatf("period_ones(code %0d)", cur_code), win_ones, win_exp);
          win_on = 1'b0;
        end
      end
      if (o_load) begin
        loads_seen++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_pop: load seen with empty scoreboard (got load, expected none)");
        end else begin
          e = sb_q.pop_front();
          if (e.fresh) residue = 0;
          cur_code = int'(e.code);
          open_window();
        end
      end else if (o_underrun) begin
        unders_seen++;
        open_window();
      end
    end
  end

  task automatic send(input logic [BITS-1:0] code);
    bit rdy = 1'b0;
    for (int i = 0; i < 64 && !rdy; i++) begin
      if (o_ready) rdy = 1'b1;
      else @(negedge clk);
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: o_ready got 0 expected 1 within 64 cycles");
    end
    i_valid = 1'b1;
    i_data  = code;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_pulse();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = o_load | o_underrun;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL pulse_timeout: load/underrun got 0 expected 1 within 40 cycles");
    end
  endtask

  initial begin : main
    int base_l, base_u, exp_l, exp_u;
    logic [BITS-1:0] code;
    bit gone;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    check("reset_ready", o_ready, 1);
    check("reset_busy", o_busy, 0);
    check("reset_load", o_load, 0);
    check("reset_underrun", o_underrun, 0);
    check("reset_dac", o_dac, 0);

    // Latency of the first sample, then underruns repeating it.
    i_enable = 1'b1;
    sb_q.push_back('{code: 4'd5, fresh: 1'b1});
    i_valid = 1'b1;
    i_data  = 4'd5;
    @(negedge clk);
    i_valid = 1'b0;
    check("accept_ready_low", o_ready, 0);
    check("accept_no_load_yet", o_load, 0);
    check("accept_not_busy", o_busy, 0);
    @(negedge clk);
    check("load_latency", o_load, 1);
    check("load_busy", o_busy, 1);
    check("load_ready_back", o_ready, 1);
    base_l = loads_seen;
    base_u = unders_seen;
    for (int p = 0; p < 3; p++) begin
      wait_pulse();
      check("underrun_pulse", o_underrun, 1);
      check("underrun_busy", o_busy, 1);
    end
    check("underrun_count", unders_seen - base_u, 3);
    check("underrun_no_load", loads_seen - base_l, 0);

    // Alternating extreme codes, refilled every period.
    base_u = unders_seen;
    for (int k = 0; k < 6; k++) begin
      code = (k % 2 == 0) ? 4'd0 : 4'd15;
      sb_q.push_back('{code: code, fresh: 1'b0});
      send(code);
      wait_pulse();
      check("refill_load", o_load, 1);
    end
    check("refill_no_underrun", unders_seen - base_u, 0);

    // Random refills with random gaps.
    base_l = loads_seen;
    base_u = unders_seen;
    exp_l  = 0;
    exp_u  = 0;
    for (int it = 0; it < 24; it++) begin
      bit do_send;
      do_send = ($urandom_range(3, 0) != 0);
      if (do_send) begin
        repeat ($urandom_range(10, 0)) @(negedge clk);
        code = BITS'($urandom_range(MOD - 1, 0));
        sb_q.push_back('{code: code, fresh: 1'b0});
        send(code);
        exp_l++;
      end else begin
        exp_u++;
      end
      wait_pulse();
      check("rand_kind", o_load, int'(do_send));
    end
    check("rand_loads", loads_seen - base_l, exp_l);
    check("rand_underruns", unders_seen - base_u, exp_u);

    // Stop mid-period with a sample buffered.
    send(4'd9);
    repeat (4) @(negedge clk);
    i_enable = 1'b0;
    base_l = loads_seen;
    gone = 1'b0;
    for (int i = 0; i < 40 && !gone; i++) begin
      @(negedge clk);
      gone = !o_busy;
    end
    check("stop_idle", int'(gone), 1);
    check("stop_no_load", loads_seen - base_l, 0);
    check("stop_buffer_kept", o_ready, 0);
    @(negedge clk);
    check("stop_dac_zero", o_dac, 0);
    repeat (5) @(negedge clk);
    check("idle_disabled_busy", o_busy, 0);
    check("idle_disabled_ready", o_ready, 0);
    check("idle_disabled_dac", o_dac, 0);

    sb_q.push_back('{code: 4'd9, fresh: 1'b1});
    i_enable = 1'b1;
    wait_pulse();
    check("restart_load", o_load, 1);

    // Reset mid-period with buffer full and a sample offered.
    send(4'd3);
    repeat (5) @(negedge clk);
    i_valid = 1'b1;
    i_data  = 4'd7;
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    i_valid = 1'b0;
    check("midreset_ready", o_ready, 1);
    check("midreset_busy", o_busy, 0);
    check("midreset_load", o_load, 0);
    check("midreset_underrun", o_underrun, 0);
    check("midreset_dac", o_dac, 0);
    base_l = loads_seen;
    repeat (4) @(negedge clk);
    check("midreset_no_capture_busy", o_busy, 0);
    check("midreset_no_capture_ready", o_ready, 1);
    check("midreset_no_capture_load", loads_seen - base_l, 0);
    check("scoreboard_drained", sb_q.size(), 0);

    for (int i = 0; i < 2000 && !done20; i++) @(negedge clk);
    check("osr20_finished", int'(done20), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Non-power-of-two period: one sample of code 9, then repeated underruns.
  initial begin : osr20
    int res20, ones, mid, total;
    bit got;
    res20 = 0;
    got   = 1'b0;
    wait (i_reset == 1'b0);
    @(negedge clk);
    i_enable20 = 1'b1;
    i_valid20  = 1'b1;
    i_data20   = 4'd9;
    @(negedge clk);
    i_valid20 = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = o_load20;
    end
    check("osr20_load", int'(got), 1);
    for (int p = 0; p < 5; p++) begin
      ones = 0;
      mid  = 0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        ones += int'(o_dac20);
        if (k < 20) mid += int'(o_load20 | o_underrun20);
      end
      total = res20 + 20 * 9;
      check("osr20_ones", ones, total / MOD);
      res20 = total % MOD;
      check("osr20_boundary", o_underrun20, 1);
      check("osr20_no_early_pulse", mid, 0);
    end
    done20 = 1'b1;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
